// File: rtl/counter_ctl_pkg.sv
// Shared types and widths for the configurable debug counter.
package counter_ctl_pkg;

  localparam int unsigned MODE_W = 2;

  // Count rule selected by the mode input
  typedef enum logic [MODE_W-1:0] {
    FREE    = 2'd0,
    MOD     = 2'd1,
    SAT     = 2'd2,
    ONESHOT = 2'd3
  } mode_t;

endpackage

// File: rtl/counter_ctl_next.sv
// Combinational next-count calculator: applies one step under the selected mode.
module counter_ctl_next
  import counter_ctl_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STEP_W = 8
) (
  input  logic [WIDTH-1:0]  q,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              up,
  input  mode_t             mode,
  output logic [WIDTH-1:0]  q_next_c,
  output logic              wrap_c,
  output logic              at_bound_c
);

  // One extra bit so the carry/borrow of the step is visible
  localparam int unsigned EXT_W = WIDTH + 1;

  logic [EXT_W-1:0] q_ext;
  logic [EXT_W-1:0] step_ext;
  logic [EXT_W-1:0] lim_ext;
  logic [EXT_W-1:0] sum;
  logic [EXT_W-1:0] diff;
  logic             step_zero;
  logic             sat_hit;
  logic [WIDTH-1:0] sat_q;
  logic [WIDTH-1:0] bound;

  assign q_ext     = EXT_W'(q);
  assign step_ext  = EXT_W'(step);
  assign lim_ext   = EXT_W'(limit);
  assign sum       = q_ext + step_ext;
  assign diff      = q_ext - step_ext;
  assign step_zero = (step == '0);

  // Saturating result shared by SAT and ONESHOT; bound is limit going up, 0 going down
  always_comb begin
    sat_hit = 1'b0;
    sat_q   = q;
    bound   = '0;
    if (up) begin
      bound   = limit;
      sat_hit = (sum >= lim_ext);
      sat_q   = sat_hit ? limit : sum[WIDTH-1:0];
    end else begin
      bound   = '0;
      sat_hit = (q_ext <= step_ext);
      sat_q   = sat_hit ? '0 : diff[WIDTH-1:0];
    end
  end

  // Mode rules; a zero step always holds with no terminal count
  always_comb begin
    q_next_c   = q;
    wrap_c     = 1'b0;
    at_bound_c = 1'b0;
    if (!step_zero) begin
      case (mode)
        FREE: begin
          if (up) begin
            q_next_c = sum[WIDTH-1:0];
            wrap_c   = sum[WIDTH];
          end else begin
            q_next_c = diff[WIDTH-1:0];
            wrap_c   = diff[WIDTH];
          end
        end
        MOD: begin
          if (up) begin
            if (sum > lim_ext) begin
              q_next_c = '0;
              wrap_c   = 1'b1;
            end else begin
              q_next_c = sum[WIDTH-1:0];
            end
          end else begin
            if (diff[WIDTH]) begin
              q_next_c = limit;
              wrap_c   = 1'b1;
            end else begin
              q_next_c = diff[WIDTH-1:0];
            end
          end
        end
        SAT: begin
          // Pulse only on first arrival, not while parked at the bound
          q_next_c   = sat_q;
          at_bound_c = sat_hit && (q != bound);
        end
        ONESHOT: begin
          // Any arrival at the bound ends the run, even if already sitting there
          q_next_c   = sat_q;
          at_bound_c = sat_hit;
        end
      endcase
    end
  end

endmodule

// File: rtl/counter_ctl.sv
// General-purpose debug counter: registers, command priority and sticky status flags.
module counter_ctl
  import counter_ctl_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STEP_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ce,
  input  logic              sclr,
  input  logic              up,
  input  logic              load,
  input  logic [WIDTH-1:0]  l,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic [MODE_W-1:0] mode,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic              ovf,
  output logic              done
);

  mode_t            mode_e;
  logic [WIDTH-1:0] step_q;
  logic             step_wrap;
  logic             step_bound;

  logic [WIDTH-1:0] q_d;
  logic             tc_d;
  logic             ovf_d;
  logic             done_d;

  assign mode_e = mode_t'(mode);

  counter_ctl_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .q          (q),
    .step       (step),
    .limit      (limit),
    .up         (up),
    .mode       (mode_e),
    .q_next_c   (step_q),
    .wrap_c     (step_wrap),
    .at_bound_c (step_bound)
  );

  // Next register values: sclr > load > ce > hold; tc defaults low so it is a single-cycle pulse
  always_comb begin
    q_d    = q;
    tc_d   = 1'b0;
    ovf_d  = ovf;
    done_d = done;
    if (sclr) begin
      q_d    = '0;
      ovf_d  = 1'b0;
      done_d = 1'b0;
    end else if (load) begin
      q_d    = l;
      done_d = 1'b0;
    end else if (ce && !done) begin
      q_d    = step_q;
      tc_d   = step_wrap || step_bound;
      ovf_d  = ovf || step_wrap;
      done_d = (mode_e == ONESHOT) && step_bound;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      q    <= '0;
      tc   <= 1'b0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      q    <= q_d;
      tc   <= tc_d;
      ovf  <= ovf_d;
      done <= done_d;
    end
  end

endmodule
